pmem_line_responder: RTL and testbench

Memory-side responder for the L1 cache's physical-memory line interface. It accepts one 128-bit line read or write at a time from the cache controller/datapath and services it from an internal line store after a programmable latency. It answers with a single-cycle pmem_resp. It serves as the main-memory model and as the template for a later L2 responder.

---
 rtl/lc3b_types.sv | 21 ++
 rtl/pmem_line_responder_line_store.sv | 25 ++
 rtl/pmem_line_responder.sv | 120 ++++++++++++
 tb/tb_pmem_line_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b bus types plus the physical-memory line interface definitions.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_data;

    localparam int unsigned lc3b_pmem_offset_bits = 4;

    typedef enum logic {
        PMEM_OP_READ  = 1'b0,
        PMEM_OP_WRITE = 1'b1
    } pmem_op_t;

    typedef enum logic [1:0] {
        PMEM_IDLE    = 2'd0,
        PMEM_WAIT    = 2'd1,
        PMEM_RESP    = 2'd2,
        PMEM_RECOVER = 2'd3
    } pmem_state_t;

endpackage

// File: rtl/pmem_line_responder_line_store.sv
// Line storage array: synchronous write, asynchronous read, contents never reset.
module line_store #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/pmem_line_responder.sv
// Main-memory line responder: accepts one line read/write at a time and answers
// with a single-cycle pmem_resp after LATENCY cycles, then one recovery cycle.
module pmem_line_responder
    import lc3b_types::*;
#(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned LINE_BITS = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     pmem_read,
    input  logic     pmem_write,
    input  lc3b_word pmem_address,
    input  lc3b_data pmem_wdata,
    output logic     pmem_resp,
    output lc3b_data pmem_rdata,
    output logic     busy
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DEPTH = 1 << LINE_BITS;

    pmem_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    pmem_op_t             op_q, op_d;
    logic [LINE_BITS-1:0] idx_q, idx_d;
    lc3b_data             wdata_q, wdata_d;
    logic                 resp_q, resp_d;
    lc3b_data             rdata_q, rdata_d;
    logic                 busy_q, busy_d;

    logic [LINE_BITS-1:0] req_idx_c;
    lc3b_data             store_rdata_c;
    logic                 store_we_c;
    logic                 unused_addr_c;

    assign req_idx_c     = pmem_address[lc3b_pmem_offset_bits +: LINE_BITS];
    assign unused_addr_c = ^pmem_address;

    // Next-state, latency counter and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        unique case (state_q)
            PMEM_IDLE: begin
                if (pmem_read || pmem_write) begin
                    op_d    = pmem_write ? PMEM_OP_WRITE : PMEM_OP_READ;
                    idx_d   = req_idx_c;
                    wdata_d = pmem_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? PMEM_RESP : PMEM_WAIT;
                end
            end
            PMEM_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = PMEM_RESP;
                end
            end
            PMEM_RESP:    state_d = PMEM_RECOVER;
            PMEM_RECOVER: state_d = PMEM_IDLE;
            default:      state_d = PMEM_IDLE;
        endcase
        resp_d = (state_d == PMEM_RESP);
        busy_d = (state_d != PMEM_IDLE);
    end

    // Read data is loaded on the RESP entry edge and otherwise held.
    always_comb begin
        rdata_d = rdata_q;
        if ((state_d == PMEM_RESP) && (state_q != PMEM_RESP) && (op_d == PMEM_OP_READ)) begin
            rdata_d = store_rdata_c;
        end
    end

    // Writes commit on the RESP exit edge.
    assign store_we_c = (state_q == PMEM_RESP) && (op_q == PMEM_OP_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PMEM_IDLE;
            cnt_q   <= '0;
            op_q    <= PMEM_OP_READ;
            idx_q   <= '0;
            wdata_q <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    line_store #(
        .WIDTH($bits(lc3b_data)),
        .DEPTH(DEPTH)
    ) u_store (
        .clk    (clk),
        .we     (store_we_c),
        .waddr  (idx_q),
        .wdata  (wdata_q),
        .raddr  (idx_d),
        .rdata_c(store_rdata_c)
    );

    assign pmem_resp  = resp_q;
    assign pmem_rdata = rdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench for pmem_line_responder (LATENCY=4 and LATENCY=1 instances).
module tb_pmem_line_responder;
    import lc3b_types::*;

    localparam int unsigned LAT  = 4;
    localparam int unsigned LB   = 8;
    localparam int unsigned LAT1 = 1;
    localparam int unsigned LB1  = 4;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     pmem_read, pmem_write, pmem_resp, busy;
    lc3b_word pmem_address;
    lc3b_data pmem_wdata, pmem_rdata;
    logic     rd1, wr1, resp1, busy1;
    lc3b_word addr1;
    lc3b_data wd1, rdata1;

    always #5 clk = ~clk;

    pmem_line_responder #(.LATENCY(LAT), .LINE_BITS(LB)) u_dut (
        .clk(clk), .rst_n(rst_n), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
        .pmem_rdata(pmem_rdata), .busy(busy)
    );

    pmem_line_responder #(.LATENCY(LAT1), .LINE_BITS(LB1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pmem_read(rd1), .pmem_write(wr1),
        .pmem_address(addr1), .pmem_wdata(wd1), .pmem_resp(resp1),
        .pmem_rdata(rdata1), .busy(busy1)
    );

    int n_chk = 0;
    int n_err = 0;
    lc3b_data mem_m [256];
    lc3b_data last_rd;

    typedef struct {
        bit       rd;
        bit       wr;
        lc3b_word addr;
        lc3b_data wd;
        lc3b_data exp;
    } vec_t;

    vec_t tbl [7];

    function automatic lc3b_data init_pat(input int unsigned i);
        return {4{32'hC0DE_0000 | 32'(i)}};
    endfunction

    function automatic int unsigned idx_of(input lc3b_word a);
        return 32'(a[4 +: LB]);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Posedges from the current negedge until pmem_resp is seen at a negedge.
    task automatic wait_resp(output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (pmem_resp === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_resp1(output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp1 === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // One full transaction on the LATENCY=4 instance, starting and ending idle at a negedge.
    task automatic apply(input string name, input bit rd, input bit wr, input lc3b_word addr,
                         input lc3b_data wd, input lc3b_data exp, input bit scramble);
        int n;
        int unsigned ix;
        ix           = idx_of(addr);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        if (scramble) begin
            @(posedge clk);
            @(negedge clk);
            pmem_address = 16'($urandom);
            pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
            wait_resp(n);
            if (n > 0) n++;
        end else begin
            wait_resp(n);
        end
        chk({name, " latency"}, 128'(n), 128'(LAT));
        chk({name, " rdata"}, pmem_rdata, exp);
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({name, " resp width"}, 128'(pmem_resp), 128'(0));
        chk({name, " recover busy"}, 128'(busy), 128'(1));
        @(posedge clk);
        @(negedge clk);
        chk({name, " idle busy"}, 128'(busy), 128'(0));
        if (wr) mem_m[ix] = wd;
        else    last_rd   = mem_m[ix];
    endtask

    initial begin
        int n;
        int unsigned r;
        bit rb, wb, sc;
        lc3b_word a;
        lc3b_data d, e;
        lc3b_data p1, wa;

        pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
        last_rd = '0;
        rst_n   = 1'b0;
        #3;
        chk("reset resp", 128'(pmem_resp), 128'(0));
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset rdata", pmem_rdata, 128'(0));
        chk("reset busy l1", 128'(busy1), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // LATENCY=1 instance: write, then a held read answered twice.
        p1   = 128'h5555_0000_1111_2222_3333_4444_6666_7777;
        wr1  = 1'b1; addr1 = 16'h0050; wd1 = p1;
        wait_resp1(n);
        chk("l1 write latency", 128'(n), 128'(LAT1));
        chk("l1 write rdata", rdata1, 128'(0));
        wr1 = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rd1 = 1'b1;
        wait_resp1(n);
        chk("l1 read latency", 128'(n), 128'(LAT1));
        chk("l1 read rdata", rdata1, p1);
        wait_resp1(n);
        chk("l1 held spacing", 128'(n), 128'(LAT1 + 2));
        chk("l1 held rdata", rdata1, p1);
        rd1 = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);

        // Give every line of the main store a known pattern.
        for (int i = 0; i < 256; i++) begin
            apply("init", 1'b0, 1'b1, 16'(i << 4), init_pat(i), last_rd, 1'b0);
        end

        tbl[0] = '{1'b0, 1'b1, 16'h1230, 128'h0123456789ABCDEF0123456789ABCDEF, 128'h0};
        tbl[1] = '{1'b1, 1'b0, 16'h1238, 128'h0, 128'h0123456789ABCDEF0123456789ABCDEF};
        tbl[2] = '{1'b1, 1'b1, 16'h0040, {32{4'hA}}, 128'h0123456789ABCDEF0123456789ABCDEF};
        tbl[3] = '{1'b1, 1'b0, 16'h0040, 128'h0, {32{4'hA}}};
        tbl[4] = '{1'b0, 1'b1, 16'h1000, 128'hDEADBEEF_FEEDFACE_0BADF00D_CAFEBABE, {32{4'hA}}};
        tbl[5] = '{1'b1, 1'b0, 16'h2000, 128'h0, 128'hDEADBEEF_FEEDFACE_0BADF00D_CAFEBABE};
        tbl[6] = '{1'b1, 1'b0, 16'h0FF0, 128'h0, init_pat(255)};
        for (int i = 0; i < 7; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd,
                  tbl[i].exp, 1'b0);
        end

        // Random traffic against the line-array model; inputs may change after acceptance.
        for (int k = 0; k < 80; k++) begin
            r  = $urandom_range(0, 2);
            rb = (r != 1);
            wb = (r != 0);
            a  = 16'($urandom);
            d  = {$urandom, $urandom, $urandom, $urandom};
            sc = 1'($urandom_range(0, 1));
            e  = wb ? last_rd : mem_m[idx_of(a)];
            apply($sformatf("rand%0d", k), rb, wb, a, d, e, sc);
        end

        // Writeback followed immediately by the allocate read.
        wa = 128'h1357_9BDF_2468_ACE0_FDB9_7531_0ECA_8642;
        pmem_write = 1'b1; pmem_address = 16'h0370; pmem_wdata = wa;
        wait_resp(n);
        chk("wa write latency", 128'(n), 128'(LAT));
        chk("wa write rdata", pmem_rdata, last_rd);
        pmem_write = 1'b0; pmem_read = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("wa recover resp", 128'(pmem_resp), 128'(0));
        chk("wa recover busy", 128'(busy), 128'(1));
        wait_resp(n);
        chk("wa read accept", 128'(n), 128'(LAT + 1));
        chk("wa read rdata", pmem_rdata, wa);
        pmem_read = 1'b0;
        mem_m[idx_of(16'h0370)] = wa;
        last_rd = wa;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);

        // Reset two cycles into a write must abort it.
        pmem_write = 1'b1; pmem_address = 16'h0100; pmem_wdata = {16{8'h3C}};
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("rst pre busy", 128'(busy), 128'(1));
        chk("rst pre rdata", pmem_rdata, last_rd);
        rst_n = 1'b0;
        #1;
        chk("rst async resp", 128'(pmem_resp), 128'(0));
        chk("rst async busy", 128'(busy), 128'(0));
        chk("rst async rdata", pmem_rdata, 128'(0));
        pmem_write = 1'b0;
        last_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply("rst readback", 1'b1, 1'b0, 16'h0100, 128'h0, mem_m[idx_of(16'h0100)], 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
